imm_extend_pipe: RTL and testbench

- Registered, parametrised immediate extender for the decode stage; successor to the combinational RV32i extender.
- Generalised to XLEN = 32 or 64; adds CSR zero-immediate and an illegal-select flag.
- Has a valid/ready handshake with a 2-entry skid buffer, so In_Ready is a registered signal and decode→execute timing is cut.
- Sits between instruction fetch/decode logic and the ID/EX register; honours pipeline Flush.

---
 rtl/imm_extend_pipe_pkg.sv | 23 ++
 rtl/imm_extend_pipe_imm_format_xlen.sv | 48 ++++
 rtl/imm_extend_pipe.sv | 122 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - shared types for the registered immediate extender
// Optional feature macro: IMM_ZICSR_EN (IMM_Z is only legal in consumers built with it)
package imm_extend_pipe_pkg;

  localparam int CLOCK_PERIOD = 10;

  // IMM_Z is always enumerated; consumers decide whether it is legal.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_Z = 3'd5
  } imm_type_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/imm_extend_pipe_imm_format_xlen.sv
// rtl/imm_extend_pipe_imm_format_xlen.sv - combinational RISC-V immediate format and extend
// Optional feature macro: IMM_ZICSR_EN (select 5 yields zero-extended Instr[19:15])
module imm_format_xlen
  import imm_extend_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $fatal(1, "imm_format_xlen: XLEN must be 32 or 64");
  end

  logic [31:0] raw;
  logic        zimm;
  logic        unused_opcode;

  // The opcode field never contributes to any immediate.
  assign unused_opcode = ^instr[6:0];

  // Build a 32-bit value already sign-extended from bit 31, then widen to XLEN.
  always_comb begin
    raw  = '0;
    err  = 1'b0;
    zimm = 1'b0;
    case (imm_type_t'(sel))
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      IMM_Z:   zimm = 1'b1;
`endif
      default: err = 1'b1;
    endcase
  end

  // Every format (including U on RV64) sign-extends from Instr[31]; CSR uimm zero-extends.
  assign imm = zimm ? XLEN'(instr[19:15]) :
               err  ? '0                  :
                      XLEN'($signed(raw));

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate extender with 2-entry skid buffer
// Optional feature macro: IMM_ZICSR_EN (enables CSR zero-immediate select)
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Flush,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       Imm_Type_Sel,
  input  logic [TAG_W-1:0] In_Tag,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [XLEN-1:0]  Imm_Ext,
  output logic [TAG_W-1:0] Out_Tag,
  output logic             Imm_Err
);

  logic [XLEN-1:0]  fmt_imm;
  logic             fmt_err;
  occ_state_t       state, next_state;
  logic             accept, drain;
  logic             load_out, load_skid, out_from_skid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  // Formatting happens before storage so both registers hold final values.
  imm_format_xlen #(.XLEN(XLEN)) u_fmt (
    .instr (Instr),
    .sel   (Imm_Type_Sel),
    .imm   (fmt_imm),
    .err   (fmt_err)
  );

  assign accept    = In_Valid & In_Ready & ~Flush;
  assign drain     = Out_Valid & Out_Ready;
  assign Out_Valid = (state != ST_EMPTY);

  // Occupancy state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_EMPTY;
    else        state <= next_state;
  end

  // Next occupancy and register load controls; Flush overrides everything.
  always_comb begin
    next_state    = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          next_state = ST_ONE;
          load_out   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          next_state = ST_FULL;
          load_skid  = 1'b1;
        end else if (drain) begin
          next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drain) begin
          next_state    = ST_ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: next_state = ST_EMPTY;
    endcase
    if (Flush) begin
      next_state = ST_EMPTY;
      load_out   = 1'b0;
      load_skid  = 1'b0;
    end
  end

  // In_Ready is a flop: low exactly while the skid entry is occupied.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) In_Ready <= 1'b1;
    else        In_Ready <= (next_state != ST_FULL);
  end

  // Output register: loads from the formatter or from the skid, otherwise holds.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Imm_Ext <= '0;
      Out_Tag <= '0;
      Imm_Err <= 1'b0;
    end else if (load_out) begin
      Imm_Ext <= out_from_skid ? skid_imm : fmt_imm;
      Out_Tag <= out_from_skid ? skid_tag : In_Tag;
      Imm_Err <= out_from_skid ? skid_err : fmt_err;
    end
  end

  // Skid register catches the entry accepted while the output is stalled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      skid_imm <= '0;
      skid_tag <= '0;
      skid_err <= 1'b0;
    end else if (load_skid) begin
      skid_imm <= fmt_imm;
      skid_tag <= In_Tag;
      skid_err <= fmt_err;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed and random bench for imm_extend_pipe (XLEN 32 and 64)
module tb_imm_extend_pipe;
  import imm_extend_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  sel;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  integer checks = 0;
  integer errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        err;
    logic [31:0] ins;
    logic [2:0]  s;
  } exp_t;

  always #(CLOCK_PERIOD/2) clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .CLK(clk), .RST_N(rst_n), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_ready32),
    .Instr(instr), .Imm_Type_Sel(sel), .In_Tag(in_tag), .Out_Valid(out_valid32),
    .Out_Ready(out_ready), .Imm_Ext(imm32), .Out_Tag(tag32), .Imm_Err(err32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .CLK(clk), .RST_N(rst_n), .Flush(flush), .In_Valid(in_valid), .In_Ready(in_ready64),
    .Instr(instr), .Imm_Type_Sel(sel), .In_Tag(in_tag), .Out_Valid(out_valid64),
    .Out_Ready(out_ready), .Imm_Ext(imm64), .Out_Tag(tag64), .Imm_Err(err64)
  );

  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] s,
                                            output logic e);
    logic [63:0] r;
    logic        sg;
    sg = ins[31];
    e  = 1'b0;
    case (s)
      3'd0: r = {{52{sg}}, ins[31:20]};
      3'd1: r = {{52{sg}}, ins[31:25], ins[11:7]};
      3'd2: r = {{51{sg}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'd3: r = {{32{sg}}, ins[31:12], 12'b0};
      3'd4: r = {{43{sg}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef IMM_ZICSR_EN
      3'd5: r = {59'b0, ins[19:15]};
`endif
      default: begin r = 64'b0; e = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                       input logic [4:0] t);
    in_valid = v;
    instr    = ins;
    sel      = s;
    in_tag   = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 3'd0, 5'd31);
    repeat (3) step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready32); end
    checks++; if (imm64 !== 64'b0) begin errors++; $display("FAIL reset_imm got %h want 0", imm64); end
    checks++; if (tag32 !== 5'd0 || err32 !== 1'b0) begin errors++; $display("FAIL reset_tag_err got %h/%b want 0/0", tag32, err32); end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_formats32();
    logic [31:0] exp_fmt [5];
    exp_fmt = '{32'h0000_02A2, 32'h0000_02B4, 32'h0000_02B4, 32'h2A2A_2000, 32'h000A_22A2};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h2A2A_2A2A, 3'(i), 5'(i + 1));
      step();
      checks++; if (out_valid32 !== 1'b1 || imm32 !== exp_fmt[i]) begin errors++; $display("FAIL fmt32_sel%0d got v=%b %h want v=1 %h", i, out_valid32, imm32, exp_fmt[i]); end
      checks++; if (imm64 !== {32'b0, exp_fmt[i]} || tag64 !== 5'(i + 1)) begin errors++; $display("FAIL fmt64_sel%0d got %h tag %0d want %h tag %0d", i, imm64, tag64, {32'b0, exp_fmt[i]}, i + 1); end
    end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL fmt_drain_empty got %b want 0", out_valid32); end
  endtask

  task automatic test_xlen64();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFF0_0093, 3'd0, 5'd7);
    step();
    checks++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL x64_i got %h want ffffffffffffffff", imm64); end
    checks++; if (imm32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL x32_i got %h want ffffffff", imm32); end
    drive(1'b1, 32'h8000_00B7, 3'd3, 5'd8);
    step();
    checks++; if (imm64 !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL x64_u got %h want ffffffff80000000", imm64); end
    checks++; if (imm32 !== 32'h8000_0000) begin errors++; $display("FAIL x32_u got %h want 80000000", imm32); end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 32'h0010_0000, 3'd0, 5'd1);
    step();
    checks++; if (in_ready32 !== 1'b1 || out_valid32 !== 1'b1) begin errors++; $display("FAIL bp_one got rdy=%b v=%b want 1/1", in_ready32, out_valid32); end
    drive(1'b1, 32'h0020_0000, 3'd0, 5'd2);
    step();
    checks++; if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b/%b want 0", in_ready32, in_ready64); end
    drive(1'b1, 32'h0030_0000, 3'd0, 5'd3);
    step();
    step();
    checks++; if (in_ready32 !== 1'b0 || tag32 !== 5'd1 || imm32 !== 32'd1) begin errors++; $display("FAIL bp_hold got rdy=%b tag=%0d imm=%h want 0/1/1", in_ready32, tag32, imm32); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid32 !== 1'b1 || tag32 !== 5'd2 || imm32 !== 32'd2) begin errors++; $display("FAIL bp_second got v=%b tag=%0d imm=%h want 1/2/2", out_valid32, tag32, imm32); end
    step();
    checks++; if (out_valid32 !== 1'b1 || tag32 !== 5'd3 || imm32 !== 32'd3) begin errors++; $display("FAIL bp_third got v=%b tag=%0d imm=%h want 1/3/3", out_valid32, tag32, imm32); end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL bp_nodup got v=%b tag=%0d want v=0", out_valid32, tag32); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0040_0000, 3'd0, 5'd4); step();
    drive(1'b1, 32'h0050_0000, 3'd0, 5'd5); step();
    checks++; if (in_ready32 !== 1'b0) begin errors++; $display("FAIL flush_prefull got %b want 0", in_ready32); end
    drive(1'b1, 32'h0060_0000, 3'd0, 5'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin errors++; $display("FAIL flush_full got v=%b rdy=%b want 0/1", out_valid32, in_ready32); end
    drive(1'b1, 32'h0090_0000, 3'd0, 5'd9); step();
    drive(1'b1, 32'h00A0_0000, 3'd0, 5'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1) begin errors++; $display("FAIL flush_one got v=%b/%b rdy=%b want 0/0/1", out_valid32, out_valid64, in_ready32); end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    out_ready = 1'b1;
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL flush_dropped got v=%b tag=%0d want v=0", out_valid32, tag32); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 3'd7, 5'd11);
    step();
    checks++; if (out_valid32 !== 1'b1 || imm32 !== 32'b0 || err32 !== 1'b1) begin errors++; $display("FAIL illegal7_32 got v=%b %h err=%b want 1/0/1", out_valid32, imm32, err32); end
    checks++; if (imm64 !== 64'b0 || err64 !== 1'b1) begin errors++; $display("FAIL illegal7_64 got %h err=%b want 0/1", imm64, err64); end
    drive(1'b1, 32'h2A2A_2A2A, 3'd5, 5'd12);
    step();
`ifdef IMM_ZICSR_EN
    checks++; if (imm64 !== 64'h14 || err64 !== 1'b0 || imm32 !== 32'h14) begin errors++; $display("FAIL zimm got %h/%h err=%b want 14/14/0", imm32, imm64, err64); end
`else
    checks++; if (imm64 !== 64'h0 || err64 !== 1'b1 || imm32 !== 32'h0 || err32 !== 1'b1) begin errors++; $display("FAIL sel5_illegal got %h/%h err=%b want 0/0/1", imm32, imm64, err64); end
`endif
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h0010_0000, 3'd1, 5'd13); step();
    drive(1'b1, 32'h0020_0000, 3'd1, 5'd14); step();
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin errors++; $display("FAIL areset_valid got %b/%b want 0", out_valid32, out_valid64); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", in_ready32); end
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL areset_after got %b want 0", out_valid32); end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic ee;
    int   sent;
    int   got;
    int   cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 500 && cyc < 20000) begin
      if (sent < 500) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr    = $urandom;
        sel      = 3'($urandom_range(0, 7));
        in_tag   = 5'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++; if (out_valid32 !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, out_valid32, q.size() != 0); end
      if (out_valid32 && out_ready && q.size() > 0) begin
        e = q.pop_front();
        got++;
        checks++; if (imm64 !== e.imm || err64 !== e.err || tag64 !== e.tag) begin errors++; $display("FAIL rnd64 #%0d got %h/%b/%0d want %h/%b/%0d", got, imm64, err64, tag64, e.imm, e.err, e.tag); end
        checks++; if (imm32 !== e.imm[31:0] || err32 !== e.err || tag32 !== e.tag) begin errors++; $display("FAIL rnd32 #%0d got %h/%b/%0d want %h/%b/%0d", got, imm32, err32, tag32, e.imm[31:0], e.err, e.tag); end
        if (!e.err && e.s != 3'd5) begin
          checks++; if (imm64[63] !== e.ins[31]) begin errors++; $display("FAIL rnd_sign #%0d got %b want %b", got, imm64[63], e.ins[31]); end
        end
        if (e.s == 3'd2 || e.s == 3'd4) begin
          checks++; if (imm64[0] !== 1'b0) begin errors++; $display("FAIL rnd_lsb #%0d got %b want 0", got, imm64[0]); end
        end
        if (e.s == 3'd3) begin
          checks++; if (imm64[11:0] !== 12'h0) begin errors++; $display("FAIL rnd_ulow #%0d got %h want 000", got, imm64[11:0]); end
        end
      end
      if (in_valid && in_ready32) begin
        e.imm = model_imm(instr, sel, ee);
        e.err = ee;
        e.tag = in_tag;
        e.ins = instr;
        e.s   = sel;
        q.push_back(e);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++; if (got != 500) begin errors++; $display("FAIL rnd_timeout got %0d want 500", got); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats32();
    test_xlen64();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
